// File: rtl/beat_tone_player_if.sv
// ----------------------------------------------------------------------------
// beat_tone_player_if
//
// Signal bundle between the beat generator side and the tone player.
//
//   beat      : beat-detected level/pulse, slow (10 ms) domain
//   beat_int  : 2-bit beat intensity, slow domain
//   sample    : 8-bit unsigned audio sample
//   audio_pwm : 1-bit PWM encoding of sample for a speaker/RC filter
//   playing   : high while a tone envelope is active
//
// master : the side that drives beat/beat_int (beat generator, testbench)
// slave  : the tone player itself
// ----------------------------------------------------------------------------
interface beat_tone_player_if;
   logic       beat;
   logic [1:0] beat_int;
   logic [7:0] sample;
   logic       audio_pwm;
   logic       playing;

   modport master (
      output beat,
      output beat_int,
      input  sample,
      input  audio_pwm,
      input  playing
   );

   modport slave (
      input  beat,
      input  beat_int,
      output sample,
      output audio_pwm,
      output playing
   );
endinterface

// File: rtl/beat_tone_player.sv
// ----------------------------------------------------------------------------
// beat_tone_player
//
// Plays a square-wave tone on each detected beat. The tone amplitude comes
// from the beat intensity, is held for a number of envelope ticks and then
// decays linearly to silence. The result is an 8-bit sample plus a PWM
// stream of that sample.
//
// Ports:
//   clk   : 50 MHz system clock
//   rst_n : asynchronous reset, active low
//   bus   : beat_tone_player_if.slave
//           (beat, beat_int in; sample, audio_pwm, playing out)
//
// Parameters:
//   TONE_DIV    : clk cycles per half-period of the tone
//   TICK_CYCLES : clk cycles per envelope tick
//   HOLD_TICKS  : ticks at full amplitude before decay (0 behaves as 1)
//   DECAY_DEC   : amplitude decrement per decay tick
// ----------------------------------------------------------------------------
module beat_tone_player #(
   parameter int TONE_DIV    = 56818,
   parameter int TICK_CYCLES = 500000,
   parameter int HOLD_TICKS  = 5,
   parameter int DECAY_DEC   = 16
) (
   input logic               clk,
   input logic               rst_n,
   beat_tone_player_if.slave bus
);

   localparam int TONE_W   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam int TICK_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
   localparam int HOLD_W   = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EFF - 1);
   localparam logic [8:0]        DEC9      = 9'(DECAY_DEC);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } state_t;

   logic              beat_s1, beat_s2, beat_s3;
   logic [1:0]        int_s1, int_s2;
   logic              trig;

   state_t            state, state_nxt;
   logic [7:0]        amp, amp_nxt;
   logic              phase, phase_nxt;
   logic [TONE_W-1:0] tone_cnt, tone_nxt;
   logic [TICK_W-1:0] tick_cnt, tick_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;

   logic              phase_adv;
   logic [TONE_W-1:0] tone_adv;
   logic              tick_wrap;
   logic [TICK_W-1:0] tick_adv;
   logic [8:0]        amp_dec;
   logic [7:0]        amp_load;

   logic [7:0]        sample_q;
   logic [7:0]        pwm_cnt;
   logic              pwm_q;

   // Two-flop synchronisers for the slow-domain inputs; beat_s3 keeps the
   // previous synchronised beat so a rising edge yields a single trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_s1 <= 1'b0;
         beat_s2 <= 1'b0;
         beat_s3 <= 1'b0;
         int_s1  <= 2'd0;
         int_s2  <= 2'd0;
      end else begin
         beat_s1 <= bus.beat;
         beat_s2 <= beat_s1;
         beat_s3 <= beat_s2;
         int_s1  <= bus.beat_int;
         int_s2  <= int_s1;
      end
   end

   assign trig = beat_s2 & ~beat_s3;

   // Intensity to peak amplitude; the top level saturates at 255.
   always_comb begin
      amp_load = 8'd64;
      case (int_s2)
         2'd0:    amp_load = 8'd64;
         2'd1:    amp_load = 8'd128;
         2'd2:    amp_load = 8'd192;
         default: amp_load = 8'd255;
      endcase
   end

   // Free-running helpers: the tone divider/phase and the envelope tick
   // counter as they would advance this cycle, plus the 9-bit decay result
   // whose top bit flags an underflow.
   always_comb begin
      tone_adv  = tone_cnt + TONE_W'(1);
      phase_adv = phase;
      if (tone_cnt == TONE_LAST) begin
         tone_adv  = '0;
         phase_adv = ~phase;
      end
      tick_wrap = (tick_cnt == TICK_LAST);
      tick_adv  = tick_wrap ? '0 : tick_cnt + TICK_W'(1);
      amp_dec   = {1'b0, amp} - DEC9;
   end

   // Envelope FSM next-state logic. A trigger while a tone is playing
   // overrides everything else (including a coinciding tick wrap or the
   // final decay step) and keeps the tone phase running so there is no click.
   always_comb begin
      state_nxt = state;
      amp_nxt   = amp;
      phase_nxt = phase;
      tone_nxt  = tone_cnt;
      tick_nxt  = tick_cnt;
      hold_nxt  = hold_cnt;

      case (state)
         IDLE: begin
            amp_nxt   = 8'd0;
            phase_nxt = 1'b0;
            tone_nxt  = '0;
            tick_nxt  = '0;
            hold_nxt  = '0;
            if (trig) begin
               state_nxt = HOLD;
               amp_nxt   = amp_load;
               phase_nxt = 1'b1;
            end
         end
         HOLD: begin
            phase_nxt = phase_adv;
            tone_nxt  = tone_adv;
            tick_nxt  = tick_adv;
            if (tick_wrap) begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nxt = DECAY;
                  hold_nxt  = '0;
               end else begin
                  hold_nxt = hold_cnt + HOLD_W'(1);
               end
            end
         end
         DECAY: begin
            phase_nxt = phase_adv;
            tone_nxt  = tone_adv;
            tick_nxt  = tick_adv;
            if (tick_wrap) begin
               if (amp_dec[8] || (amp_dec[7:0] == 8'd0)) begin
                  state_nxt = IDLE;
                  amp_nxt   = 8'd0;
                  phase_nxt = 1'b0;
                  tone_nxt  = '0;
                  tick_nxt  = '0;
               end else begin
                  amp_nxt = amp_dec[7:0];
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            amp_nxt   = 8'd0;
            phase_nxt = 1'b0;
            tone_nxt  = '0;
            tick_nxt  = '0;
            hold_nxt  = '0;
         end
      endcase

      if (trig && (state == HOLD || state == DECAY)) begin
         state_nxt = HOLD;
         amp_nxt   = amp_load;
         phase_nxt = phase_adv;
         tone_nxt  = tone_adv;
         tick_nxt  = '0;
         hold_nxt  = '0;
      end
   end

   // Envelope and tone state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         amp      <= 8'd0;
         phase    <= 1'b0;
         tone_cnt <= '0;
         tick_cnt <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         amp      <= amp_nxt;
         phase    <= phase_nxt;
         tone_cnt <= tone_nxt;
         tick_cnt <= tick_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Registered sample and PWM: the sample lags amp/phase by one cycle and
   // the PWM compares a free-running 8-bit ramp against that sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q <= 8'd0;
         pwm_cnt  <= 8'd0;
         pwm_q    <= 1'b0;
      end else begin
         sample_q <= phase ? amp : 8'd0;
         pwm_cnt  <= pwm_cnt + 8'd1;
         pwm_q    <= (pwm_cnt < sample_q);
      end
   end

   assign bus.sample    = sample_q;
   assign bus.audio_pwm = pwm_q;
   assign bus.playing   = (state == HOLD) || (state == DECAY);

endmodule
